// File: rtl/bexkat_spi_pkg.sv
// Shared definitions for the SPI mailbox: FSM encoding, command layout,
// bus address map and a byte-lane merge helper.
package bexkat_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } spiState_e;

    localparam int          CMD_WRITE_BIT = 7;
    localparam logic [3:0]  ADR_STATUS    = 4'd8;
    localparam logic [3:0]  ADR_RESERVED  = 4'd9;

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                               input logic [31:0] newWord,
                                               input logic [3:0]  sel);
        logic [31:0] result;
        for (int b = 0; b < 4; b++) begin
            result[8*b +: 8] = sel[b] ? newWord[8*b +: 8] : oldWord[8*b +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_mailbox_sync.sv
// Multi-flop synchronizer for one asynchronous SPI line, with rise/fall
// detection taken from the last two synchronized samples.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
        end else begin
            chain_q <= (chain_q << 1) | STAGES'(d_i);
            prev_q  <= chain_q[STAGES-1];
        end
    end

    assign q_o    = chain_q[STAGES-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_mailbox.sv
// Eight-word mailbox shared between a mode-0 SPI slave and a single-cycle
// bus port, with a pending flag and maskable level interrupt.
module spi_mailbox
    import bexkat_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        ss_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [3:0]  adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o,
    output logic        irq_o
);

    localparam int                PRIME_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(SYNC_STAGES + 1);

    logic sclkS, sclkRise, sclkFall;
    logic ssS, ssRise, ssFall;
    logic [SYNC_STAGES-1:0] mosiChain_q;
    logic mosiS;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclkSync (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .d_i    (sclk),
        .q_o    (sclkS),
        .rise_o (sclkRise),
        .fall_o (sclkFall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ssSync (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .d_i    (ss_n),
        .q_o    (ssS),
        .rise_o (ssRise),
        .fall_o (ssFall)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) mosiChain_q <= '0;
        else        mosiChain_q <= (mosiChain_q << 1) | SYNC_STAGES'(mosi);
    end
    assign mosiS = mosiChain_q[SYNC_STAGES-1];

    spiState_e         state_q, state_d;
    logic [2:0]        bitCnt_q, bitCnt_d;
    logic [2:0]        byteCnt_q, byteCnt_d;
    logic [31:0]       rxSr_q, rxSr_d;
    logic [31:0]       txSr_q, txSr_d;
    logic              isWrite_q, isWrite_d;
    logic [2:0]        index_q, index_d;
    logic              miso_q, miso_d;
    logic [PRIME_W-1:0] primeCnt_q, primeCnt_d;
    logic              armed_q, armed_d;
    logic [31:0]       regs_q [8];
    logic [31:0]       regs_d [8];
    logic              pending_q, pending_d;
    logic              irqEn_q, irqEn_d;
    logic              irq_q, irq_d;
    logic              ack_q, ack_d;
    logic              served_q, served_d;
    logic [31:0]       dat_q, dat_d;
    logic              commit;
    logic [31:0]       rxWord;
    logic [7:0]        cmdByte;
    logic              busReq, busAccept, busWr;
    logic [31:0]       readWord;

    assign rxWord  = {rxSr_q[30:0], mosiS};
    assign cmdByte = rxWord[7:0];

    // A frame may only start once the synchronizers have refilled after
    // reset and the lines have been seen idle, so a select that was already
    // low across reset is not mistaken for a new frame.
    always_comb begin
        primeCnt_d = (primeCnt_q == PRIME_DONE) ? primeCnt_q : primeCnt_q + 1'b1;
        armed_d    = armed_q | ((primeCnt_q == PRIME_DONE) & ssS & ~sclkS);
    end

    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        byteCnt_d = byteCnt_q;
        rxSr_d    = rxSr_q;
        txSr_d    = txSr_q;
        isWrite_d = isWrite_q;
        index_d   = index_q;
        miso_d    = miso_q;
        commit    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (ssFall && armed_q) begin
                    state_d   = ST_CMD;
                    bitCnt_d  = 3'd0;
                    byteCnt_d = 3'd0;
                end
            end
            ST_CMD: begin
                miso_d = 1'b0;
                if (sclkRise) begin
                    rxSr_d   = rxWord;
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) begin
                        isWrite_d = cmdByte[CMD_WRITE_BIT];
                        index_d   = cmdByte[2:0];
                        txSr_d    = cmdByte[CMD_WRITE_BIT] ? 32'd0 : regs_q[cmdByte[2:0]];
                        byteCnt_d = 3'd0;
                        state_d   = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (sclkRise) begin
                    rxSr_d   = rxWord;
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) begin
                        byteCnt_d = byteCnt_q + 3'd1;
                        if (byteCnt_q == 3'd3) begin
                            state_d = ST_DONE;
                            commit  = isWrite_q;
                        end
                    end
                end
                if (sclkFall) begin
                    miso_d = txSr_q[31];
                    txSr_d = {txSr_q[30:0], 1'b0};
                end
            end
            ST_DONE: begin
                miso_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                miso_d  = 1'b0;
            end
        endcase
        if (ssRise) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
        end
    end

    // One ack per request: a held strobe is not re-acknowledged until it drops.
    assign busReq    = stb_i & cyc_i;
    assign busAccept = busReq & ~served_q;
    assign busWr     = busAccept & we_i;

    always_comb begin
        readWord = 32'd0;
        if (!adr_i[3])                 readWord = regs_q[adr_i[2:0]];
        else if (adr_i < ADR_RESERVED) readWord = {30'd0, irqEn_q, pending_q};
    end

    // The SPI commit is applied last so it overrides a same-cycle bus write
    // to the same word and keeps pending set over a same-cycle clear.
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        irqEn_d   = irqEn_q;
        served_d  = busReq;
        ack_d     = busAccept;
        dat_d     = busAccept ? (we_i ? 32'd0 : readWord) : dat_q;
        if (busWr) begin
            if (!adr_i[3]) begin
                regs_d[adr_i[2:0]] = mergeBytes(regs_q[adr_i[2:0]], dat_i, sel_i);
            end else if (adr_i == ADR_STATUS) begin
                if (dat_i[0]) pending_d = 1'b0;
                irqEn_d = dat_i[1];
            end
        end
        if (commit) begin
            regs_d[index_q] = rxWord;
            pending_d       = 1'b1;
        end
        irq_d = pending_d & irqEn_d;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bitCnt_q   <= 3'd0;
            byteCnt_q  <= 3'd0;
            rxSr_q     <= 32'd0;
            txSr_q     <= 32'd0;
            isWrite_q  <= 1'b0;
            index_q    <= 3'd0;
            miso_q     <= 1'b0;
            primeCnt_q <= '0;
            armed_q    <= 1'b0;
            regs_q     <= '{default: 32'd0};
            pending_q  <= 1'b0;
            irqEn_q    <= 1'b0;
            irq_q      <= 1'b0;
            ack_q      <= 1'b0;
            served_q   <= 1'b0;
            dat_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            byteCnt_q  <= byteCnt_d;
            rxSr_q     <= rxSr_d;
            txSr_q     <= txSr_d;
            isWrite_q  <= isWrite_d;
            index_q    <= index_d;
            miso_q     <= miso_d;
            primeCnt_q <= primeCnt_d;
            armed_q    <= armed_d;
            regs_q     <= regs_d;
            pending_q  <= pending_d;
            irqEn_q    <= irqEn_d;
            irq_q      <= irq_d;
            ack_q      <= ack_d;
            served_q   <= served_d;
            dat_q      <= dat_d;
        end
    end

    assign miso    = miso_q;
    assign miso_oe = ~ssS;
    assign ack_o   = ack_q;
    assign dat_o   = dat_q;
    assign irq_o   = irq_q;

endmodule

// File: doc/spi_mailbox.md
SPI_MAILBOX -- requirements
Module: spi_mailbox

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for sclk, ss_n and mosi into clk_i.
REQ-002 Port clk_i  input  1  system clock; requires f(clk_i) >= 8x f(sclk).
REQ-003 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port sclk  input  1  SPI clock from the external host, mode 0.
REQ-005 Port ss_n  input  1  SPI select from the external host, active-low, frames a transaction.
REQ-006 Port mosi  input  1  SPI data, host to block.
REQ-007 Port miso  output  1  SPI data, block to host.
REQ-008 Port miso_oe  output  1  miso drive enable; equals synchronized ~ss_n; top level tristates miso when low.
REQ-009 Port adr_i  input  4  bus word index: 0-7 mailbox registers, 8 status/control.
REQ-010 Port dat_i  input  32  bus write data.
REQ-011 Port dat_o  output  32  bus read data.
REQ-012 Port sel_i  input  4  bus byte enables; sel_i[3] covers dat_i[31:24].
REQ-013 Port we_i, stb_i, cyc_i  input  1 each  bus write, strobe and cycle.
REQ-014 Port ack_o  output  1  bus acknowledge.
REQ-015 Port irq_o  output  1  interrupt to the CPU interrupt hierarchy, level, active-high.

Function
REQ-016 Storage SHALL be eight 32-bit mailbox registers, shared by the bus and SPI sides.
REQ-017 SPI inputs SHALL pass through SYNC_STAGES flops; sclk rise/fall SHALL be detected from the last two synchronized samples.
REQ-018 mosi SHALL be sampled on detected sclk rise; miso SHALL update on detected sclk fall; bits are MSB first.
REQ-019 The FSM states SHALL be IDLE, CMD, DATA and DONE.
REQ-020 IDLE->CMD on synchronized ss_n fall; bit counter (3b) and byte counter (3b) cleared.
REQ-021 Command byte: bit7 = 1 write / 0 read; bits[2:0] = register index; bits[6:3] ignored; miso = 0 during CMD.
REQ-022 CMD->DATA after 8th rise; on a read, the TX shift register SHALL snapshot reg[index] that cycle, and miso SHALL present bit31 at the next sclk fall.
REQ-023 DATA SHALL carry 4 bytes; write data is accumulated MSB first in a 32-bit RX shift register.
REQ-024 DATA->DONE after 32nd data bit; on a write, reg[index] SHALL be committed in that clk_i cycle and status.pending set.
REQ-025 In DONE, further bits SHALL be ignored, miso = 0, with no register side effects.
REQ-026 Synchronized ss_n rise in any state SHALL return to IDLE; a frame aborted before the 32nd data bit SHALL commit nothing.
REQ-027 Bus: stb_i & cyc_i SHALL produce ack_o one cycle later, high for exactly one cycle per request; ack_o stays low while stb_i remains high after that ack.
REQ-028 Bus reads of 0-7 SHALL return reg[adr_i]; 8 SHALL return {30'b0, irq_en, pending}; 9-15 SHALL return 0; dat_o is valid with ack_o.
REQ-029 Bus writes of 0-7 SHALL update only the bytes enabled by sel_i; at 8, dat_i[0]=1 clears pending (write-1-clear) and dat_i[1] loads irq_en; 9-15 are ignored and still acked.
REQ-030 If an SPI commit and a bus write hit the same register in the same cycle, the SPI commit SHALL win; the bus write is dropped but still acked.
REQ-031 If an SPI commit and a bus pending-clear occur in the same cycle, pending SHALL end set.
REQ-032 irq_o SHALL equal pending & irq_en, registered.

Reset
REQ-033 While rst_n is low: miso=0, miso_oe=0, ack_o=0, irq_o=0, dat_o=0, FSM=IDLE, counters=0, pending=0, irq_en=0, all registers=0, synchronizers=ss_n-high/sclk-low.
REQ-034 Reset asserted mid-frame SHALL abandon the frame; after release, the block SHALL wait for a fresh ss_n fall.

Structure
REQ-035 FSM state encoding, command-bit position, and register indices 8/9 SHALL live in a shared package, bexkat_spi_pkg.
REQ-036 A single sub-module spi_sync (a SYNC_STAGES-deep synchronizer plus edge detect) SHALL be instantiated for sclk and ss_n; mosi SHALL use the synchronizer only.

Verification
REQ-037 SPI write: cmd 0x83 + bytes DE AD BE EF -> reg3=0xDEADBEEF, pending=1; irq_o=0 while irq_en=0.
REQ-038 Bus write reg5=0x12345678 with sel=0xF, then SPI cmd 0x05 + 4 dummy bytes -> miso returns 12 34 56 78; a bus read of reg5 acks in 1 cycle.
REQ-039 Write status=0x2, then SPI write to reg0 -> irq_o=1; write status=0x1 -> irq_o=0 next cycle.
REQ-040 SPI write to reg2 aborted after 2 data bytes -> reg2 unchanged, pending=0, FSM=IDLE.
REQ-041 Bus write reg1=0xFFFFFFFF in the SPI commit cycle of 0x81 + 00000001 -> reg1=0x00000001; bus write with sel=0x2 of 0xAAAAAAAA -> reg1=0x0000AA01.
REQ-042 rst_n pulsed low mid-read -> all outputs 0 immediately; the next full write frame completes normally.
